// File: rtl/pipe_chain.sv
// Elastic register chain: per-slot valid/ready with bubble collapse, global stall,
// masked flush and a commit-order tag that travels with each transaction.
module pipe_chain #(
    parameter int DATA_W  = 32,
    parameter int STAGES  = 4,
    parameter int ORDER_W = 64,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ORDER_W-1:0] out_order,
    input  logic               stall,
    input  logic               flush,
    input  logic [STAGES-1:0]  flush_mask,
    output logic [OCC_W-1:0]   occupancy,
    output logic [ORDER_W-1:0] next_order
);

    logic [STAGES-1:0]              r_valid;
    logic [STAGES-1:0][DATA_W-1:0]  r_data;
    logic [STAGES-1:0][ORDER_W-1:0] r_tag;
    logic [ORDER_W-1:0]             r_order;
    logic [OCC_W-1:0]               r_occ;

    logic [STAGES-1:0] w_kill;
    logic [STAGES-1:0] w_move;
    logic [STAGES-1:0] w_can;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_nxt;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_accept;

    // Ready ripples from the output slot back towards the input slot.
    always_comb begin : ready_chain
        logic w_carry;
        w_kill  = flush ? flush_mask : '0;
        w_move  = '0;
        w_can   = '0;
        w_carry = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_move[i] = r_valid[i] & ~w_kill[i] & w_carry;
            w_can[i]  = ~r_valid[i] | w_kill[i] | w_move[i];
            w_carry   = w_can[i];
        end
    end

    assign in_ready   = ~stall & w_can[0] & ~flush;
    assign out_valid  = ~stall & r_valid[STAGES-1] & ~w_kill[STAGES-1];
    assign out_data   = r_data[STAGES-1];
    assign out_order  = r_tag[STAGES-1];
    assign occupancy  = r_occ;
    assign next_order = r_order;
    assign w_accept   = in_valid & in_ready;

    // A slot is live next cycle if it loads, or it held and was neither killed nor drained.
    always_comb begin
        w_load    = '0;
        w_load[0] = w_accept;
        for (int i = 1; i < STAGES; i++) begin
            w_load[i] = ~stall & w_move[i-1];
        end
        w_valid_nxt = '0;
        w_occ_nxt   = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_valid_nxt[i] = w_load[i] | (r_valid[i] & ~w_kill[i] & ~(~stall & w_move[i]));
            w_occ_nxt      = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_order <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            if (w_accept) begin
                r_order <= r_order + ORDER_W'(1);
            end
        end
    end

    // Payload and tag need no reset; validity is carried by r_valid alone.
    always_ff @(posedge clk) begin
        if (w_load[0]) begin
            r_data[0] <= in_data;
            r_tag[0]  <= r_order;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (w_load[i]) begin
                r_data[i] <= r_data[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: scoreboard of (data, tag) pushed on input
// handshake and popped on output handshake, plus per-step directed checks.
module tb_pipe_chain;
    localparam int DW = 16;
    localparam int ST = 4;
    localparam int OW = 4;
    localparam int CW = $clog2(ST + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [OW-1:0] out_order;
    logic          stall;
    logic          flush;
    logic [ST-1:0] flush_mask;
    logic [CW-1:0] occupancy;
    logic [OW-1:0] next_order;

    always #5 clk = ~clk;

    pipe_chain #(.DATA_W(DW), .STAGES(ST), .ORDER_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_order  (out_order),
        .stall      (stall),
        .flush      (flush),
        .flush_mask (flush_mask),
        .occupancy  (occupancy),
        .next_order (next_order)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [OW-1:0] t;
    } item_t;

    int            vectors     = 0;
    int            miscompares = 0;
    item_t         sb[$];
    logic [OW-1:0] exp_order   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((occupancy != 0) && (n < 30)) begin
            step();
            n++;
        end
        at_neg();
        chk({tag, "_occ"}, 64'(occupancy), 64'(0));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    // Scoreboard monitor, sampling between edges.
    always @(negedge clk) begin
        if (rst) begin
            item_t e;
            chk("next_order", 64'(next_order), 64'(exp_order));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_order", 64'(out_order), 64'(e.t));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(item_t'{d: in_data, t: exp_order});
                exp_order = exp_order + 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0; flush_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        at_neg();
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_next_order", 64'(next_order), 64'(0));

        // A, B, C back to back, out_ready high
        step();
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hA0A0;
        at_neg(); chk("t1_in_ready", 64'(in_ready), 64'(1));
        step(); in_data = 16'hB0B0;
        step(); in_data = 16'hC0C0;
        step(); in_valid = 1'b0;
        at_neg();
        chk("t1_occ_peak", 64'(occupancy), 64'(3));
        chk("t1_no_out_yet", 64'(out_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            step(); at_neg();
            chk("t1_out_valid", 64'(out_valid), 64'(1));
            chk("t1_tag", 64'(out_order), 64'(k));
        end
        step(); at_neg();
        chk("t1_empty_out_valid", 64'(out_valid), 64'(0));
        chk("t1_empty_occ", 64'(occupancy), 64'(0));

        // Backpressure: 5 offers into a stalled output
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 16'hD000 + 16'(k);
            at_neg();
            chk("t2_in_ready", 64'(in_ready), 64'(k < 4));
            if (k < 4) step();
        end
        chk("t2_occ_full", 64'(occupancy), 64'(4));
        step(); at_neg();
        chk("t2_held", 64'(in_ready), 64'(0));
        step();
        out_ready = 1'b1;
        at_neg();
        chk("t2_accept_same_cycle", 64'(in_ready), 64'(1));
        chk("t2_emit_same_cycle", 64'(out_valid), 64'(1));
        chk("t2_first_tag", 64'(out_order), 64'(3));
        step(); in_valid = 1'b0;
        at_neg();
        chk("t2_occ_unchanged", 64'(occupancy), 64'(4));
        drain("t2_drain");

        // Single item runs to slot 3, then three more collapse behind it
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hE000;
        step(); in_valid = 1'b0;
        step(); step(); step();
        at_neg();
        chk("t3_occ1", 64'(occupancy), 64'(1));
        chk("t3_at_out", 64'(out_valid), 64'(1));
        chk("t3_tag", 64'(out_order), 64'(8));
        step();
        for (int k = 1; k < 4; k++) begin
            in_valid = 1'b1; in_data = 16'hE000 + 16'(k);
            at_neg();
            chk("t3_in_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_valid = 1'b0;
        at_neg();
        chk("t3_occ_full", 64'(occupancy), 64'(4));
        chk("t3_in_ready_full", 64'(in_ready), 64'(0));
        chk("t3_head_tag", 64'(out_order), 64'(8));

        // Flush the two youngest slots of a full chain while offering input
        step();
        flush = 1'b1; flush_mask = 4'b0011; in_valid = 1'b1; in_data = 16'hF00F;
        at_neg();
        chk("t4_in_ready_flush", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0; in_valid = 1'b0;
        void'(sb.pop_back());
        void'(sb.pop_back());
        at_neg();
        chk("t4_occ", 64'(occupancy), 64'(2));
        chk("t4_next_order", 64'(next_order), 64'(12));
        chk("t4_in_ready_after", 64'(in_ready), 64'(1));

        // Stall for 3 cycles with a flush of slot 2 in the last one
        step();
        stall = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                flush = 1'b1; flush_mask = 4'b0100;
            end
            at_neg();
            chk("t5_out_valid", 64'(out_valid), 64'(0));
            chk("t5_in_ready", 64'(in_ready), 64'(0));
            chk("t5_occ", 64'(occupancy), 64'(2));
            chk("t5_tag_hold", 64'(out_order), 64'(8));
            chk("t5_data_hold", 64'(out_data), 64'(16'hE000));
            step();
        end
        flush = 1'b0;
        sb.delete(1);
        at_neg();
        chk("t5_flush_in_stall", 64'(occupancy), 64'(1));
        chk("t5_still_stalled", 64'(out_valid), 64'(0));
        step();
        stall = 1'b0;
        drain("t5_drain");

        // Reset in the middle of traffic
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h6060;
        step(); step();
        in_valid = 1'b0; rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_occ", 64'(occupancy), 64'(0));
        chk("t6_rst_order", 64'(next_order), 64'(0));
        sb.delete();
        exp_order = '0;
        step();
        rst = 1'b1;

        // 17 items through a 4-bit tag counter
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1; in_data = 16'h7000 + 16'(k);
            at_neg();
            chk("t7_in_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_valid = 1'b0;
        at_neg();
        chk("t7_wrap_next_order", 64'(next_order), 64'(1));
        drain("t7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
